// File: rtl/pulse_meter_pkg.sv
// Shared types and default sizing for the pulse width meter.
package pulse_meter_pkg;

    localparam int unsigned DEF_CNT_W     = 5;
    localparam int unsigned DEF_MAX_WIDTH = 20;
    localparam int unsigned DEF_MIN_WIDTH = 2;

    typedef enum logic [1:0] {
        StArm,
        StIdle,
        StMeasure,
        StSaturated
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop single-bit synchronizer with synchronous active-high reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pulse_meter.sv
// Measures high time of pulse_in in clk cycles and holds the result until acknowledged.
// Define PULSE_METER_SYNC_EN to pass pulse_in through a 2-flop synchronizer first.
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned MAX_WIDTH = DEF_MAX_WIDTH,
    parameter int unsigned MIN_WIDTH = DEF_MIN_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pulse_in,
    input  logic             ack,
    input  logic             clr,
    output logic             valid,
    output logic [CNT_W-1:0] width,
    output logic             short_p,
    output logic             overflow,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_WIDTH);

    logic s;

`ifdef PULSE_METER_SYNC_EN
    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pulse_in),
        .q     (s)
    );
`else
    assign s = pulse_in;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             publish, publish_ovf;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StArm;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StArm:       if (!s) state_d = StIdle;
            StIdle:      if (s) state_d = StMeasure;
            StMeasure: begin
                if (!s) begin
                    state_d = StIdle;
                end else if (count_q == MaxCnt) begin
                    state_d = StSaturated;
                end
            end
            StSaturated: if (!s) state_d = StIdle;
            default:     state_d = StArm;
        endcase
    end

    always_comb begin
        publish     = 1'b0;
        publish_ovf = 1'b0;
        if (!s) begin
            unique case (state_q)
                StMeasure:   publish = 1'b1;
                StSaturated: begin
                    publish     = 1'b1;
                    publish_ovf = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Count holds at MaxCnt once reached, so it never wraps.
    always_comb begin
        count_d = count_q;
        if (state_q == StIdle && s) begin
            count_d = CNT_W'(1);
        end else if (state_q == StMeasure && s && count_q != MaxCnt) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    logic             valid_q, valid_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic             short_q, short_d;
    logic             ovf_q, ovf_d;
    logic             overrun_q, overrun_d;
    logic             drop;

    // A pending, unacknowledged result wins; the new one is discarded.
    assign drop = publish && valid_q && !ack;

    always_comb begin
        valid_d   = valid_q;
        width_d   = width_q;
        short_d   = short_q;
        ovf_d     = ovf_q;
        if (publish && !drop) begin
            valid_d = 1'b1;
            width_d = count_q;
            short_d = 32'(count_q) < MIN_WIDTH;
            ovf_d   = publish_ovf;
        end else if (valid_q && ack) begin
            valid_d = 1'b0;
        end
        overrun_d = drop || (overrun_q && !clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            width_q   <= '0;
            short_q   <= 1'b0;
            ovf_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            width_q   <= width_d;
            short_q   <= short_d;
            ovf_q     <= ovf_d;
            overrun_q <= overrun_d;
        end
    end

    assign valid    = valid_q;
    assign width    = width_q;
    assign short_p  = short_q;
    assign overflow = ovf_q;
    assign overrun  = overrun_q;

endmodule

// File: doc/pulse_meter.md
PULSE_METER -- requirements
Module: pulse_meter

Interface
REQ-001 SHALL have parameter CNT_W, default 5: width of the pulse-width counter and result.
REQ-002 SHALL have parameter MAX_WIDTH, default 20: saturation width in clk cycles (1..2^CNT_W-1).
REQ-003 SHALL have parameter MIN_WIDTH, default 2: widths below this are flagged short.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 pulse_in  input  1  pulse to measure; asynchronous to clk when PULSE_METER_SYNC_EN is defined.
REQ-007 ack  input  1  consumer accepts the held result.
REQ-008 clr  input  1  clears the sticky overrun flag.
REQ-009 valid  output  1  held result present.
REQ-010 width  output  CNT_W  measured high time in clk cycles.
REQ-011 short_p  output  1  held result width < MIN_WIDTH.
REQ-012 overflow  output  1  held result saturated at MAX_WIDTH.
REQ-013 overrun  output  1  sticky: a completed result was dropped.

Function
REQ-014 s is the sampled pulse (see Configuration); all decisions use s at rising clk.
REQ-015 FSM states: ARM, IDLE, MEASURE, SATURATED.
REQ-016 ARM: s==0 -> IDLE; otherwise stay (no partial pulse after reset is measured).
REQ-017 IDLE: s==1 -> MEASURE with count<=1.
REQ-018 MEASURE: s==1 and count<MAX_WIDTH -> count<=count+1; s==1 and count==MAX_WIDTH -> SATURATED; s==0 -> publish count, IDLE.
REQ-019 SATURATED: count frozen at MAX_WIDTH; s==0 -> publish with overflow=1, IDLE.
REQ-020 Publish: width<=count, short_p<=(count<MIN_WIDTH), overflow per state, valid<=1, all at the same edge that samples s==0.
REQ-021 A pulse with s high for N consecutive edges yields width=min(N,MAX_WIDTH); valid is first visible after the edge sampling the first s==0.
REQ-022 Result registers and valid hold until ack is sampled high while valid==1, then valid<=0.
REQ-023 Publish while valid==1 and ack==0: new result dropped, old result held, overrun<=1.
REQ-024 Publish while valid==1 and ack==1: new result loaded, valid stays 1, overrun unchanged.
REQ-025 ack while valid==0 SHALL be ignored.
REQ-026 overrun clears only on clr or reset; clr coincident with a drop leaves overrun=1.
REQ-027 Counter SHALL never wrap; MAX_WIDTH bound is exact.

Reset
REQ-028 reset SHALL force state ARM, count=0, valid=0, width=0, short_p=0, overflow=0, overrun=0, synchronizer flops=0, on the next rising clk.
REQ-029 reset mid-pulse SHALL discard the in-flight measurement; measuring resumes only after s is seen low.

Configuration
REQ-030 Macro PULSE_METER_SYNC_EN defined: pulse_in passes a 2-flop synchronizer, s lags pulse_in by 2 cycles.
REQ-031 Macro undefined: s=pulse_in directly (pulse_in must be synchronous to clk), 0 added latency; all other behaviour identical.

Structure
REQ-032 Package pulse_meter_pkg SHALL hold the FSM state enum and default CNT_W/MAX_WIDTH/MIN_WIDTH constants.
REQ-033 Sub-module sync_2ff (1-bit, sync reset to 0) SHALL implement the synchronizer; instantiated only under PULSE_METER_SYNC_EN.

Verification (CNT_W=5, MAX_WIDTH=20, MIN_WIDTH=2, both macro settings)
REQ-034 pulse_in high 7 cycles, ack held low -> valid=1, width=7, short_p=0, overflow=0, held until ack, then valid=0 next cycle.
REQ-035 pulse_in high 1 cycle -> width=1, short_p=1.
REQ-036 pulse_in high 25 cycles -> valid stays 0 during pulse; after fall width=20, overflow=1.
REQ-037 pulses of 5 then 9 cycles, no ack -> width=5 held, overrun=1; clr pulse -> overrun=0.
REQ-038 second result publishes in the same cycle ack=1 -> valid stays 1, width updates 5->9, overrun=0.
REQ-039 reset asserted during cycle 4 of a 10-cycle pulse -> no result; reset released with s high -> ARM until low; next 3-cycle pulse -> width=3.
